execute_stage: RTL and testbench

Execute stage of the 5-stage pipelined RV32I core, sitting between the ID/EX register and the memory stage.
- Selects ALU operands from the register file, MEM-stage or WB-stage values, using the forwarding selects from the hazard unit.
- Computes the ALU result, branch decision and branch target.
- Registers results into the EX/MEM pipeline register. Its registered `RD_M`/`RegWriteM` outputs feed back into the hazard unit.

---
 rtl/execute_stage_if.sv | 45 ++++
 rtl/execute_stage.sv | 106 ++++++++++
 tb/tb_execute_stage.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// EX-stage bus: ID/EX inputs, branch resolution and the EX/MEM register outputs.
interface execute_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            RegWriteE;
  logic            MemWriteE;
  logic [1:0]      ResultSrcE;
  logic            BranchE;
  logic            JumpE;
  logic [2:0]      ALUControlE;
  logic            ALUSrcE;
  logic [XLEN-1:0] RD1_E;
  logic [XLEN-1:0] RD2_E;
  logic [XLEN-1:0] Imm_Ext_E;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic [4:0]      RD_E;
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic [XLEN-1:0] ResultW;

  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            RegWriteM;
  logic            MemWriteM;
  logic [1:0]      ResultSrcM;
  logic [4:0]      RD_M;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] WriteDataM;
  logic [XLEN-1:0] PCPlus4M;

  modport master (
    output RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUControlE, ALUSrcE,
           RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, ForwardAE, ForwardBE, ResultW,
    input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALUResultM, WriteDataM, PCPlus4M
  );

  modport slave (
    input  RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUControlE, ALUSrcE,
           RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, ForwardAE, ForwardBE, ResultW,
    output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALUResultM, WriteDataM, PCPlus4M
  );
endinterface

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution and EX/MEM register.
// Optional EXEC_STALL_EN adds a StallM port that holds the EX/MEM register.
module execute_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic           clk,
  input  logic           rst,
`ifdef EXEC_STALL_EN
  input  logic           StallM,
`endif
  execute_stage_if.slave ex
);

  localparam int unsigned RD_W  = 5;
  localparam int unsigned SRC_W = 2;

  logic            reg_write_q;
  logic            mem_write_q;
  logic [SRC_W-1:0] result_src_q;
  logic [RD_W-1:0] rd_q;
  logic [XLEN-1:0] alu_result_q;
  logic [XLEN-1:0] write_data_q;
  logic [XLEN-1:0] pc_plus4_q;

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            zero;
  logic            hold;

`ifdef EXEC_STALL_EN
  assign hold = StallM;
`else
  assign hold = 1'b0;
`endif

  // Forwarding muxes; select 11 is reserved and falls back to register data
  always_comb begin
    fwd_a = ex.RD1_E;
    case (ex.ForwardAE)
      2'b01:   fwd_a = ex.ResultW;
      2'b10:   fwd_a = alu_result_q;
      default: fwd_a = ex.RD1_E;
    endcase
  end

  always_comb begin
    fwd_b = ex.RD2_E;
    case (ex.ForwardBE)
      2'b01:   fwd_b = ex.ResultW;
      2'b10:   fwd_b = alu_result_q;
      default: fwd_b = ex.RD2_E;
    endcase
  end

  assign src_b = ex.ALUSrcE ? ex.Imm_Ext_E : fwd_b;

  // ALU
  always_comb begin
    alu_result = '0;
    case (ex.ALUControlE)
      3'b000:  alu_result = fwd_a + src_b;
      3'b001:  alu_result = fwd_a - src_b;
      3'b010:  alu_result = fwd_a & src_b;
      3'b011:  alu_result = fwd_a | src_b;
      3'b100:  alu_result = fwd_a ^ src_b;
      3'b101:  alu_result = XLEN'($signed(fwd_a) < $signed(src_b));
      default: alu_result = '0;
    endcase
  end

  assign zero         = (alu_result == '0);
  assign ex.PCSrcE    = ~rst & ((ex.BranchE & zero) | ex.JumpE);
  assign ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;

  // EX/MEM pipeline register; reset wins over stall
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
      rd_q         <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
    end else if (!hold) begin
      reg_write_q  <= ex.RegWriteE;
      mem_write_q  <= ex.MemWriteE;
      result_src_q <= ex.ResultSrcE;
      rd_q         <= ex.RD_E;
      alu_result_q <= alu_result;
      write_data_q <= fwd_b;
      pc_plus4_q   <= ex.PCPlus4E;
    end
  end

  assign ex.RegWriteM  = reg_write_q;
  assign ex.MemWriteM  = mem_write_q;
  assign ex.ResultSrcM = result_src_q;
  assign ex.RD_M       = rd_q;
  assign ex.ALUResultM = alu_result_q;
  assign ex.WriteDataM = write_data_q;
  assign ex.PCPlus4M   = pc_plus4_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: scoreboard of expected EX/MEM contents plus
// same-cycle checks of the branch outputs.
module tb_execute_stage;

  localparam int unsigned XLEN = 32;
`ifdef EXEC_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
  } mexp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  stall_m = 1'b0;
  int    n_cmp = 0;
  int    n_bad = 0;
  mexp_t q[$];
  mexp_t last_m = '0;

  always #5 clk = ~clk;

  execute_stage_if #(.XLEN(XLEN)) ex_bus ();

  execute_stage #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef EXEC_STALL_EN
    .StallM(stall_m),
`endif
    .ex    (ex_bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] model_alu(input logic [2:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    case (c)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf,
                                      input logic [31:0] resw);
    if (sel == 2'b01) return resw;
    if (sel == 2'b10) return last_m.alu;
    return rf;
  endfunction

  // Drive one EX instruction, check branch outputs, queue the expected EX/MEM contents
  task automatic issue(input logic rw, input logic mw, input logic [1:0] rs,
                       input logic br, input logic jmp, input logic [2:0] ctl,
                       input logic asrc, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd,
                       input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] resw);
    logic [31:0] a, bm, b, res;
    logic        exp_src;
    mexp_t       e;
    ex_bus.RegWriteE   = rw;
    ex_bus.MemWriteE   = mw;
    ex_bus.ResultSrcE  = rs;
    ex_bus.BranchE     = br;
    ex_bus.JumpE       = jmp;
    ex_bus.ALUControlE = ctl;
    ex_bus.ALUSrcE     = asrc;
    ex_bus.RD1_E       = rd1;
    ex_bus.RD2_E       = rd2;
    ex_bus.Imm_Ext_E   = imm;
    ex_bus.PCE         = pc;
    ex_bus.PCPlus4E    = pc + 32'd4;
    ex_bus.RD_E        = rd;
    ex_bus.ForwardAE   = fa;
    ex_bus.ForwardBE   = fb;
    ex_bus.ResultW     = resw;
    a   = fwd(fa, rd1, resw);
    bm  = fwd(fb, rd2, resw);
    b   = asrc ? imm : bm;
    res = model_alu(ctl, a, b);
    exp_src = !rst && ((br && (res == 32'd0)) || jmp);
    #1;
    check("pcsrc", {31'd0, ex_bus.PCSrcE}, {31'd0, exp_src});
    check("pctarget", ex_bus.PCTargetE, pc + imm);
    if (rst) e = '0;
    else if (STALL_EN && stall_m) e = last_m;
    else e = '{rw, mw, rs, rd, res, bm, pc + 32'd4};
    q.push_back(e);
  endtask

  // Advance one edge and compare the registered outputs against the oldest expectation
  task automatic step();
    mexp_t e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1 entries");
    end else begin
      e = q.pop_front();
      check("regwrite_m", {31'd0, ex_bus.RegWriteM}, {31'd0, e.rw});
      check("memwrite_m", {31'd0, ex_bus.MemWriteM}, {31'd0, e.mw});
      check("resultsrc_m", {30'd0, ex_bus.ResultSrcM}, {30'd0, e.rs});
      check("rd_m", {27'd0, ex_bus.RD_M}, {27'd0, e.rd});
      check("aluresult_m", ex_bus.ALUResultM, e.alu);
      check("writedata_m", ex_bus.WriteDataM, e.wd);
      check("pcplus4_m", ex_bus.PCPlus4M, e.pc4);
      last_m = e;
    end
  endtask

  initial begin
    // Reset held two cycles with busy inputs, including a jump
    rst = 1'b1;
    issue(1, 1, 2'd3, 1, 1, 3'd0, 0, 32'h11, 32'h22, 32'h40, 32'h200, 5'd9, 2'd0, 2'd0, 32'h0);
    step();
    issue(1, 1, 2'd1, 1, 1, 3'd1, 0, 32'h33, 32'h44, 32'h8, 32'h300, 5'd7, 2'd0, 2'd0, 32'h0);
    step();
    rst = 1'b0;

    // No forwarding: 5 + 7
    issue(1, 0, 2'd0, 0, 0, 3'd0, 0, 32'd5, 32'd7, 32'd0, 32'h100, 5'd3, 2'd0, 2'd0, 32'h0);
    step();
    // MEM forward on A: 12 - 3
    issue(1, 0, 2'd0, 0, 0, 3'd1, 0, 32'd100, 32'd3, 32'd0, 32'h104, 5'd4, 2'd2, 2'd0, 32'h0);
    step();
    // WB forward on B: 1 + 20
    issue(1, 0, 2'd0, 0, 0, 3'd0, 0, 32'd1, 32'd99, 32'd0, 32'h108, 5'd5, 2'd0, 2'd1, 32'd20);
    step();
    // beq taken, not taken, then jal
    issue(0, 0, 2'd0, 1, 0, 3'd1, 0, 32'h10, 32'h10, 32'h20, 32'h100, 5'd0, 2'd0, 2'd0, 32'h0);
    step();
    issue(0, 0, 2'd0, 1, 0, 3'd1, 0, 32'h10, 32'h11, 32'hFFFF_FFF0, 32'h140, 5'd0, 2'd0, 2'd0, 32'h0);
    step();
    issue(1, 0, 2'd2, 0, 1, 3'd0, 0, 32'd3, 32'd4, 32'h800, 32'h180, 5'd1, 2'd0, 2'd0, 32'h0);
    step();
    // slt signed both ways
    issue(1, 0, 2'd0, 0, 0, 3'd5, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h1C0, 5'd6, 2'd0, 2'd0, 32'h0);
    step();
    issue(1, 0, 2'd0, 0, 0, 3'd5, 0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'h1C4, 5'd6, 2'd0, 2'd0, 32'h0);
    step();
    // Wrap to zero feeds a taken branch
    issue(1, 0, 2'd0, 1, 0, 3'd0, 0, 32'hFFFF_FFFF, 32'd1, 32'h4, 32'h1C8, 5'd7, 2'd0, 2'd0, 32'h0);
    step();
    // Reserved forward select 11 acts as register data
    issue(1, 0, 2'd0, 0, 0, 3'd0, 0, 32'd4, 32'd6, 32'd0, 32'h1CC, 5'd8, 2'd3, 2'd3, 32'h55);
    step();
    // Logic ops with immediate operand; WriteData still takes RD2
    issue(1, 0, 2'd0, 0, 0, 3'd2, 1, 32'h0000_F0F0, 32'h1234, 32'h0000_FF00, 32'h1D0, 5'd10, 2'd0, 2'd0, 32'h0);
    step();
    issue(1, 0, 2'd0, 0, 0, 3'd3, 1, 32'h0000_F0F0, 32'h5678, 32'h0000_0F0F, 32'h1D4, 5'd11, 2'd0, 2'd0, 32'h0);
    step();
    issue(1, 0, 2'd0, 0, 0, 3'd4, 0, 32'hAAAA_5555, 32'hFFFF_0000, 32'd0, 32'h1D8, 5'd12, 2'd0, 2'd0, 32'h0);
    step();
    // Unused opcodes give zero; x0 destination and store controls pass through
    issue(1, 1, 2'd2, 0, 0, 3'd6, 0, 32'h7, 32'h9, 32'd0, 32'h1DC, 5'd0, 2'd0, 2'd0, 32'h0);
    step();
    issue(0, 1, 2'd1, 0, 0, 3'd7, 0, 32'h7, 32'h9, 32'd0, 32'h1E0, 5'd31, 2'd0, 2'd2, 32'h0);
    step();
    // Mid-stream reset drops the in-flight instruction
    issue(1, 0, 2'd0, 0, 0, 3'd0, 0, 32'd40, 32'd2, 32'd0, 32'h1E4, 5'd13, 2'd0, 2'd0, 32'h0);
    step();
    rst = 1'b1;
    issue(1, 1, 2'd1, 1, 1, 3'd0, 0, 32'd8, 32'd9, 32'h10, 32'h1E8, 5'd14, 2'd0, 2'd0, 32'h0);
    step();
    rst = 1'b0;
    issue(1, 0, 2'd0, 0, 0, 3'd1, 0, 32'd50, 32'd8, 32'd0, 32'h1EC, 5'd15, 2'd0, 2'd0, 32'h0);
    step();

`ifdef EXEC_STALL_EN
    // Stall freezes the register while inputs change; branch outputs stay live
    stall_m = 1'b1;
    issue(0, 1, 2'd2, 1, 0, 3'd1, 0, 32'h10, 32'h10, 32'h30, 32'h300, 5'd16, 2'd0, 2'd0, 32'h0);
    step();
    issue(1, 0, 2'd1, 0, 1, 3'd0, 0, 32'd1, 32'd2, 32'h40, 32'h304, 5'd17, 2'd2, 2'd0, 32'h0);
    step();
    issue(1, 1, 2'd3, 0, 0, 3'd4, 0, 32'hF0, 32'h0F, 32'd0, 32'h308, 5'd18, 2'd0, 2'd1, 32'h77);
    step();
    stall_m = 1'b0;
    issue(1, 0, 2'd0, 0, 0, 3'd0, 0, 32'd9, 32'd7, 32'd0, 32'h30C, 5'd19, 2'd2, 2'd0, 32'h0);
    step();
    stall_m = 1'b1;
    issue(1, 1, 2'd1, 0, 0, 3'd0, 0, 32'd2, 32'd2, 32'd0, 32'h310, 5'd20, 2'd0, 2'd0, 32'h0);
    step();
    rst = 1'b1;
    issue(1, 1, 2'd1, 0, 1, 3'd0, 0, 32'd2, 32'd2, 32'd0, 32'h314, 5'd21, 2'd0, 2'd0, 32'h0);
    step();
    rst = 1'b0;
    stall_m = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
